// File: rtl/param_counter.sv
// Purpose : up/down modulo counter with prescaler, load/clear, wrap or saturate.
// Latency : count/tc/ovf are registered; they change on the edge that samples tick/clr/load.
// Backpress: none; en gates the prescaler and the counter simply holds while en=0.
//
// Ports:
//   clk_12m   rising-edge clock (board 12 MHz domain)
//   rst_n     asynchronous active-low reset (release synchronised outside)
//   en        count enable, advances the prescaler
//   up        direction, 1 = increment, 0 = decrement
//   clr       synchronous clear of count, prescaler, tc and ovf (highest priority)
//   load      synchronous load of load_val (second priority)
//   load_val  value loaded verbatim, may exceed max_val
//   max_val   inclusive modulo limit, sampled on the tick cycle
//   ovf_clr   clears the sticky ovf flag (a simultaneous boundary tick wins)
//   count     current count
//   tc        one-cycle pulse following every tick taken at a boundary
//   ovf       sticky flag, set by any boundary tick
module param_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk_12m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic             tick;
    logic             at_bound;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    // Prescaler: one tick every PRESCALE enabled cycles. clr/load restart the
    // period so a freshly loaded value always gets a full period before stepping.
    generate
        if (PRESCALE == 1) begin : g_no_presc
            assign tick = en;
        end else begin : g_presc
            localparam int             PW         = $clog2(PRESCALE);
            localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] presc;

            always_ff @(posedge clk_12m or negedge rst_n) begin
                if (!rst_n) begin
                    presc <= '0;
                end else if (clr || load) begin
                    presc <= '0;
                end else if (en) begin
                    if (presc == PRESC_LAST) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
            end

            assign tick = en && (presc == PRESC_LAST);
        end
    endgenerate

    // Up-boundary uses >= so an out-of-range loaded value (or a max_val lowered
    // below count) is treated as "at the top" rather than counting on past it.
    always_comb begin
        if (up) begin
            at_bound = (count >= max_val);
        end else begin
            at_bound = (count == '0);
        end
    end

    // Value taken on a tick. The boundary test comes first, so the +/-1 never
    // wraps the WIDTH-bit range.
    always_comb begin
        step_val = count;
        if (!at_bound) begin
            if (up) begin
                step_val = count + WIDTH'(1);
            end else begin
                step_val = count - WIDTH'(1);
            end
        end else if (SATURATE == 0) begin
            if (up) begin
                step_val = '0;
            end else begin
                step_val = max_val;
            end
        end
    end

    // Priority: clr > load > tick > hold. ovf_clr is applied before the
    // boundary set so a coincident boundary tick keeps the flag high.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;
        if (clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = load_val;
            if (ovf_clr) begin
                ovf_nxt = 1'b0;
            end
        end else begin
            if (ovf_clr) begin
                ovf_nxt = 1'b0;
            end
            if (tick) begin
                count_nxt = step_val;
                if (at_bound) begin
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
Parametrised up/down counter with a programmable modulo limit, a built-in prescaler, load and clear, and a selectable wrap or saturate mode. It is the general-purpose counter for the hardware examples: cycle counters, LED dividers and timeouts. It runs in the board 12 MHz domain. It also provides a terminal-count pulse and a sticky overflow flag for downstream logic.

Parameters:
WIDTH, 8, counter width in bits (>=1)
PRESCALE, 1, enabled clock cycles per count step (>=1; 1 = step every enabled cycle)
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk_12m  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset; release is synchronised externally
en  in  1  count enable; gates the prescaler
up  in  1  direction: 1 = increment, 0 = decrement
clr  in  1  synchronous clear
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
max_val  in  WIDTH  modulo limit (inclusive upper bound)
ovf_clr  in  1  clears sticky ovf
count  out  WIDTH  current count
tc  out  1  one-cycle terminal-count pulse
ovf  out  1  sticky boundary-event flag

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, prescaler=0, tc=0, ovf=0. All are held while rst_n=0. Reset mid-operation discards any pending prescaler progress.
- Prescaler
  - Internal counter runs 0..PRESCALE-1 and advances only when en=1.
  - tick = en && (presc == PRESCALE-1). On tick the prescaler returns to 0.
  - When en=0 the prescaler holds.
  - With PRESCALE=1 there is no prescaler register and tick = en.
- Priority per cycle: clr > load > tick step > hold.
  - clr: count=0, prescaler=0, ovf=0, tc=0.
  - load: count=load_val (loaded verbatim, even if > max_val), prescaler=0, tc=0, ovf unchanged.
- Boundary condition at a tick:
  - up=1: boundary when count >= max_val.
  - up=0: boundary when count == 0.
- Step on tick:
  - Not at boundary: count ± 1.
  - At boundary, SATURATE=0: up sets count=0, down sets count=max_val.
  - At boundary, SATURATE=1: count holds (up holds its current value, so an out-of-range loaded value stays put).
- tc
  - Registered. tc=1 for exactly the one cycle following a tick taken at a boundary; otherwise 0.
  - In saturate mode, tc pulses on every tick while at the boundary.
- ovf
  - Set by any boundary tick.
  - Cleared by ovf_clr or clr. If ovf_clr and a boundary tick occur in the same cycle, set wins.
- max_val=0: every tick is a boundary. count stays 0 and tc pulses each tick.
- max_val may change at any time and is sampled in the same cycle as the tick. Lowering it below count makes the next up-tick a boundary.
- Direction change takes effect at the next tick; the prescaler is not disturbed.
- Latency: count, tc and ovf update on the clock edge that samples the tick, clr or load. There is no combinational path from inputs to outputs.
- Arithmetic is unsigned WIDTH-bit. The +1/-1 step never overflows the width, because the boundary check precedes the step.

Test Plan:
1. WIDTH=8, PRESCALE=1, SATURATE=0, max_val=5, up=1, en=1 for 14 cycles after reset:
   - count sequence 0,1,2,3,4,5,0,1,…
   - tc high for one cycle after each 5→0 transition; ovf=1 after the first wrap.
2. PRESCALE=4, max_val=255, up=1, en=1 for 16 cycles:
   - count=4, steps every 4th cycle.
   - Drop en for 3 cycles mid-period: count and prescaler hold, then resume with no lost or extra step.
3. SATURATE=1, up=0, load_val=2 loaded, then en=1 for 5 cycles:
   - count 2,1,0,0,0.
   - tc pulses on each tick at 0; ovf set.
   - Assert ovf_clr alone: ovf=0.
   - Assert ovf_clr together with a boundary tick: ovf stays 1.
4. SATURATE=0, max_val=9, load=1 with load_val=12, then up tick:
   - count 12 → 0, tc=1.
   - Repeat with up=0 from load 12: count → 11 (decrements normally).
5. Simultaneous clr, load and en, with count=7 and ovf=1:
   - clr wins: count=0, ovf=0, tc=0, prescaler=0.
6. Assert rst_n=0 asynchronously mid-prescale (PRESCALE=3, presc=1, count=4, tc=1):
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the first step occurs 3 enabled cycles later.
